// File: rtl/freq_gen_pkg.sv
// Shared types and constants for the BCD-programmed square-wave generator.
// num_lut returns the half-period numerator CLK*10^k/2 for a fractional-digit count k.
package freq_gen_pkg;

   localparam int DIV_W = 36;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      CONV,
      DIV,
      RUN
   } state_t;

   function automatic logic [DIV_W-1:0] num_lut(input logic [1:0] k, input longint unsigned clk_hz);
      longint unsigned v;
      case (k)
         2'd0:    v = clk_hz;
         2'd1:    v = clk_hz * 64'd10;
         2'd2:    v = clk_hz * 64'd100;
         default: v = clk_hz * 64'd1000;
      endcase
      return DIV_W'(v / 64'd2);
   endfunction

endpackage

// File: rtl/freq_generator_bcd_seq_divider.sv
// Restoring divider, one quotient bit per clock. The first step runs on the
// i_start edge straight from the inputs, so W steps finish W edges after start.
module seq_divider #(
   parameter int W = 36
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_abort,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic [W-1:0] o_quotient,
   output logic         o_busy,
   output logic         o_done
);

   localparam int CW = $clog2(W + 1);

   logic [W:0]    r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_dsr;
   logic [CW-1:0] r_cnt;
   logic          r_busy;

   logic [W:0]    w_rem_in;
   logic [W-1:0]  w_quo_in;
   logic [W-1:0]  w_dsr;
   logic [W:0]    w_shift;
   logic [W:0]    w_diff;
   logic          w_ge;

   always_comb begin
      w_rem_in = i_start ? '0 : r_rem;
      w_quo_in = i_start ? i_dividend : r_quo;
      w_dsr    = i_start ? i_divisor : r_dsr;
      w_shift  = {w_rem_in[W-1:0], w_quo_in[W-1]};
      w_ge     = (w_shift >= {1'b0, w_dsr});
      w_diff   = w_shift - {1'b0, w_dsr};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_dsr  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_abort) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (i_start || r_busy) begin
         r_quo <= {w_quo_in[W-2:0], w_ge};
         r_rem <= w_ge ? w_diff : w_shift;
         if (i_start) begin
            r_dsr  <= i_divisor;
            r_cnt  <= CW'(1);
            r_busy <= 1'b1;
         end else if (r_cnt == CW'(W - 1)) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // o_done flags the cycle whose closing edge computes the last quotient bit.
   assign o_quotient = r_quo;
   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_cnt == CW'(W - 1));

endmodule

// File: rtl/freq_generator_bcd.sv
// Square-wave source programmed by a 4-digit BCD frequency with a one-hot decimal point.
// Half-period Q = floor(CLK*10^k / (2N)) is computed once per start, then the output toggles every Q cycles.
module freq_generator_bcd
   import freq_gen_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic [3:0] i_freq_bcd3,
   input  logic [3:0] i_freq_bcd2,
   input  logic [3:0] i_freq_bcd1,
   input  logic [3:0] i_freq_bcd0,
   input  logic [3:0] i_freq_dp,
   output logic       o_signal,
   output logic       o_ready,
   output logic       o_done,
   output logic       o_error
);

   state_t           r_state;
   logic             r_signal;
   logic             r_ready;
   logic             r_done;
   logic             r_error;
   logic [15:0]      r_digits;
   logic [1:0]       r_k;
   logic [1:0]       r_idx;
   logic [DIV_W-1:0] r_acc;
   logic [DIV_W-1:0] r_cnt;

   logic [15:0]      w_in_digits;
   logic [1:0]       w_k;
   logic             w_dp_ok;
   logic             w_bad;
   logic [3:0]       w_digit;
   logic [DIV_W-1:0] w_num;
   logic [DIV_W-1:0] w_quot;
   logic [DIV_W-1:0] w_half;
   logic             w_div_start;
   logic             w_div_busy;
   logic             w_div_done;

   assign w_in_digits = {i_freq_bcd3, i_freq_bcd2, i_freq_bcd1, i_freq_bcd0};

   always_comb begin
      w_k     = 2'd0;
      w_dp_ok = 1'b1;
      case (i_freq_dp)
         4'b0001: w_k = 2'd0;
         4'b0010: w_k = 2'd1;
         4'b0100: w_k = 2'd2;
         4'b1000: w_k = 2'd3;
         default: w_dp_ok = 1'b0;
      endcase
      w_bad = !w_dp_ok || (w_in_digits == 16'h0000) ||
              (i_freq_bcd3 > 4'd9) || (i_freq_bcd2 > 4'd9) ||
              (i_freq_bcd1 > 4'd9) || (i_freq_bcd0 > 4'd9);
   end

   // CONV walks the latched digits most-significant first.
   always_comb begin
      case (r_idx)
         2'd0:    w_digit = r_digits[15:12];
         2'd1:    w_digit = r_digits[11:8];
         2'd2:    w_digit = r_digits[7:4];
         default: w_digit = r_digits[3:0];
      endcase
   end

   assign w_num       = num_lut(r_k, 64'(CLK_FREQ_HZ));
   assign w_half      = (w_quot == '0) ? DIV_W'(1) : w_quot;
   assign w_div_start = (r_state == DIV) && !w_div_busy;

   seq_divider #(
      .W (DIV_W)
   ) u_div (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_start    (w_div_start),
      .i_abort    (i_stop),
      .i_dividend (w_num),
      .i_divisor  (r_acc),
      .o_quotient (w_quot),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_signal <= 1'b0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_digits <= '0;
         r_k      <= '0;
         r_idx    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_stop) begin
            r_state  <= IDLE;
            r_signal <= 1'b0;
            r_ready  <= 1'b1;
            r_cnt    <= '0;
         end else begin
            case (r_state)
               IDLE, RUN: begin
                  if (i_start) begin
                     r_state  <= LOAD;
                     r_ready  <= 1'b0;
                     r_signal <= 1'b0;
                     r_error  <= 1'b0;
                     r_cnt    <= '0;
                  end else if (r_state == RUN) begin
                     if (r_cnt == w_half - DIV_W'(1)) begin
                        r_cnt    <= '0;
                        r_signal <= ~r_signal;
                     end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                     end
                  end
               end
               LOAD: begin
                  r_digits <= w_in_digits;
                  r_k      <= w_k;
                  r_idx    <= '0;
                  r_acc    <= '0;
                  if (w_bad) begin
                     r_state <= IDLE;
                     r_ready <= 1'b1;
                     r_error <= 1'b1;
                  end else begin
                     r_state <= CONV;
                  end
               end
               CONV: begin
                  r_acc <= (r_acc << 3) + (r_acc << 1) + DIV_W'(w_digit);
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3) begin
                     r_state <= DIV;
                  end
               end
               DIV: begin
                  // The first high half starts on the same edge the last quotient bit lands.
                  if (w_div_done) begin
                     r_state  <= RUN;
                     r_ready  <= 1'b1;
                     r_done   <= 1'b1;
                     r_signal <= 1'b1;
                     r_cnt    <= '0;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
               end
            endcase
         end
      end
   end

   assign o_signal = r_signal;
   assign o_ready  = r_ready;
   assign o_done   = r_done;
   assign o_error  = r_error;

endmodule

// File: tb/tb_freq_generator_bcd.sv
// Bench for freq_generator_bcd: two instances (1 kHz and 100 MHz clocks) share stimulus
// and are compared every cycle against a timeline model derived from the request value.
`timescale 1ns/1ps
module tb_freq_generator_bcd;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [3:0] d3 = 4'd0;
   logic [3:0] d2 = 4'd0;
   logic [3:0] d1 = 4'd0;
   logic [3:0] d0 = 4'd0;
   logic [3:0] dp = 4'b0001;
   logic [1:0] sig;
   logic [1:0] rdy;
   logic [1:0] dn;
   logic [1:0] err;

   int checks = 0;
   int errors = 0;

   // clock / reset
   always #5 clk = ~clk;

   freq_generator_bcd #(.CLK_FREQ_HZ(1000)) dut_k (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
      .i_freq_bcd3(d3), .i_freq_bcd2(d2), .i_freq_bcd1(d1), .i_freq_bcd0(d0),
      .i_freq_dp(dp),
      .o_signal(sig[0]), .o_ready(rdy[0]), .o_done(dn[0]), .o_error(err[0])
   );

   freq_generator_bcd #(.CLK_FREQ_HZ(100_000_000)) dut_m (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
      .i_freq_bcd3(d3), .i_freq_bcd2(d2), .i_freq_bcd1(d1), .i_freq_bcd0(d0),
      .i_freq_dp(dp),
      .o_signal(sig[1]), .o_ready(rdy[1]), .o_done(dn[1]), .o_error(err[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: mode 0 idle, 1 valid request, 2 rejected request
   longint m_edge = 0;
   int     m_mode [2] = '{0, 0};
   longint m_acc [2] = '{0, 0};
   longint m_q [2] = '{1, 1};
   bit     m_sticky [2] = '{1'b0, 1'b0};

   function automatic longint clk_of(input int i);
      return (i == 0) ? 64'd1000 : 64'd100_000_000;
   endfunction

   // Half-period for the current inputs, or 0 when the request must be rejected.
   function automatic longint req_q(input int i);
      longint n;
      longint p10 = 1;
      longint q;
      int k = 0;
      if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return 0;
      n = 64'(d3) * 1000 + 64'(d2) * 100 + 64'(d1) * 10 + 64'(d0);
      if (n == 0) return 0;
      case (dp)
         4'b0001: k = 0;
         4'b0010: k = 1;
         4'b0100: k = 2;
         4'b1000: k = 3;
         default: return 0;
      endcase
      for (int j = 0; j < k; j++) p10 = p10 * 10;
      q = clk_of(i) * p10 / (2 * n);
      if (q == 0) q = 1;
      return q;
   endfunction

   function automatic bit exp_ready(input int i, input longint e);
      if (m_mode[i] == 1) return (e - m_acc[i]) >= 41;
      if (m_mode[i] == 2) return (e - m_acc[i]) >= 1;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_mode[i]   = 0;
            m_sticky[i] = 1'b0;
         end
      end else begin
         bit   rb [2];
         longint q;
         for (int i = 0; i < 2; i++) rb[i] = exp_ready(i, m_edge);
         m_edge++;
         for (int i = 0; i < 2; i++) begin
            if (stop) begin
               if (m_mode[i] == 2 && (m_edge - m_acc[i]) >= 2) m_sticky[i] = 1'b1;
               m_mode[i] = 0;
            end else if (start && rb[i]) begin
               m_sticky[i] = 1'b0;
               m_acc[i]    = m_edge;
               q = req_q(i);
               if (q == 0) begin
                  m_mode[i] = 2;
               end else begin
                  m_mode[i] = 1;
                  m_q[i]    = q;
               end
            end
         end
      end
   end

   // scoreboard: every cycle, every output of both instances
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         longint d;
         bit e_sig, e_done, e_rdy, e_err;
         d      = m_edge - m_acc[i];
         e_rdy  = exp_ready(i, m_edge);
         e_done = (m_mode[i] == 1) && (d == 41);
         e_sig  = (m_mode[i] == 1) && (d >= 41) && ((((d - 41) / m_q[i]) % 2) == 0);
         e_err  = m_sticky[i] || ((m_mode[i] == 2) && (d >= 1));
         chk($sformatf("signal[%0d]", i), 64'(sig[i]), 64'(e_sig));
         chk($sformatf("ready[%0d]", i), 64'(rdy[i]), 64'(e_rdy));
         chk($sformatf("done[%0d]", i), 64'(dn[i]), 64'(e_done));
         chk($sformatf("error[%0d]", i), 64'(err[i]), 64'(e_err));
      end
   end

   // driver tasks
   task automatic set_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] e, input logic [3:0] p);
      d3 = a; d2 = b; d1 = c; d0 = e; dp = p;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic measure_k(input logic lvl, output int len);
      len = 0;
      while (sig[0] === lvl && len < 2000) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic rand_digits();
      logic [3:0] v [4];
      for (int j = 0; j < 4; j++) begin
         v[j] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 2) == 0) begin
         v[0] = 4'd0;
         v[1] = 4'd0;
      end
      d3 = v[0]; d2 = v[1]; d1 = v[2]; d0 = v[3];
      if ($urandom_range(0, 9) == 0) dp = 4'($urandom_range(0, 15));
      else dp = 4'(1 << $urandom_range(0, 3));
   endtask

   initial begin
      int len;
      repeat (3) @(negedge clk);
      chk("reset.ready", 64'(rdy), 64'(2'b11));
      chk("reset.signal", 64'(sig), 64'(2'b00));
      chk("reset.done", 64'(dn), 64'(2'b00));
      chk("reset.error", 64'(err), 64'(2'b00));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 5 Hz at 1 kHz clock -> Q = 100
      set_req(4'd0, 4'd0, 4'd0, 4'd5, 4'b0001);
      pulse_start();
      repeat (41) @(negedge clk);
      chk("k5.done", 64'(dn[0]), 64'd1);
      chk("k5.quot", 64'(dut_k.w_quot), 64'd100);
      chk("k5.model_q", 64'(m_q[0]), 64'd100);
      measure_k(1'b1, len);
      chk("k5.high_len", 64'(len), 64'd100);
      measure_k(1'b0, len);
      chk("k5.low_len", 64'(len), 64'd100);
      repeat (420) @(negedge clk);

      // restart in RUN with 2 Hz, plus an ignored start during DIV
      set_req(4'd0, 4'd0, 4'd0, 4'd2, 4'b0001);
      pulse_start();
      chk("restart.signal", 64'(sig), 64'(2'b00));
      repeat (20) @(negedge clk);
      pulse_start();
      repeat (19) @(negedge clk);
      chk("k2.done", 64'(dn[0]), 64'd1);
      chk("k2.quot", 64'(dut_k.w_quot), 64'd250);
      repeat (520) @(negedge clk);

      pulse_stop();
      chk("stop_run.signal", 64'(sig), 64'(2'b00));
      chk("stop_run.ready", 64'(rdy), 64'(2'b11));

      set_req(4'd1, 4'd0, 4'd0, 4'd0, 4'b0001);
      pulse_start();
      repeat (41) @(negedge clk);
      chk("m1000.quot", 64'(dut_m.w_quot), 64'd50000);
      chk("k1000.quot_raw", 64'(dut_k.w_quot), 64'd0);
      repeat (10) @(negedge clk);

      set_req(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100);
      pulse_start();
      repeat (41) @(negedge clk);
      chk("m1234.quot", 64'(dut_m.w_quot), 64'd4051863);
      chk("k1234.quot", 64'(dut_k.w_quot), 64'd40);
      repeat (10) @(negedge clk);

      // rejected requests: zero value, two dp bits, non-BCD digit
      for (int c = 0; c < 3; c++) begin
         case (c)
            0:       set_req(4'd0, 4'd0, 4'd0, 4'd0, 4'b0001);
            1:       set_req(4'd0, 4'd0, 4'd0, 4'd5, 4'b0011);
            default: set_req(4'd0, 4'd0, 4'hA, 4'd1, 4'b0001);
         endcase
         pulse_start();
         chk($sformatf("inv%0d.err_clear", c), 64'(err), 64'(2'b00));
         @(negedge clk);
         chk($sformatf("inv%0d.error", c), 64'(err), 64'(2'b11));
         chk($sformatf("inv%0d.ready", c), 64'(rdy), 64'(2'b11));
         chk($sformatf("inv%0d.signal", c), 64'(sig), 64'(2'b00));
         repeat (5) @(negedge clk);
      end

      set_req(4'd0, 4'd0, 4'd0, 4'd5, 4'b0001);
      pulse_start();
      chk("valid.err_clear", 64'(err), 64'(2'b00));
      repeat (60) @(negedge clk);

      // stop during CONV
      set_req(4'd0, 4'd0, 4'd0, 4'd3, 4'b0001);
      pulse_start();
      repeat (2) @(negedge clk);
      pulse_stop();
      repeat (60) @(negedge clk);

      // stop and start together: stop wins
      @(negedge clk);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      chk("stopstart.ready", 64'(rdy), 64'(2'b11));
      chk("stopstart.signal", 64'(sig), 64'(2'b00));
      repeat (50) @(negedge clk);

      // asynchronous reset in the middle of DIV
      pulse_start();
      repeat (20) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst.ready", 64'(rdy), 64'(2'b11));
      chk("arst.signal", 64'(sig), 64'(2'b00));
      chk("arst.done", 64'(dn), 64'(2'b00));
      chk("arst.error", 64'(err), 64'(2'b00));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      set_req(4'd0, 4'd0, 4'd0, 4'd4, 4'b0001);
      pulse_start();
      repeat (41) @(negedge clk);
      chk("arst.after_done", 64'(dn), 64'(2'b11));
      chk("arst.after_quot", 64'(dut_k.w_quot), 64'd125);
      repeat (30) @(negedge clk);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!start && $urandom_range(0, 7) == 0) rand_digits();
         start = ($urandom_range(0, 59) == 0);
         stop  = ($urandom_range(0, 149) == 0);
      end
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
